// File: rtl/panel_input_pkg.sv
// rtl/panel_input_pkg.sv - shared constants and helpers for the panel input conditioner
// Purpose: input counts, raw idle levels and the counter-width helper.
// Ports: none (package).
package panel_input_pkg;

  localparam int NUM_KEYS     = 4;
  localparam int NUM_SWITCHES = 10;

  // Raw pin levels when nothing is touched: keys are active-low, switches rest down.
  localparam logic KEY_IDLE    = 1'b1;
  localparam logic SWITCH_IDLE = 1'b0;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchroniser, debouncer and edge pulse generator
// Purpose: accepts a new level after DEBOUNCE_CYCLES consecutive disagreeing
//          synchronised samples; optional inversion makes the output active-high.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_raw           raw asynchronous input
//   o_level         debounced level (after optional inversion)
//   o_rise, o_fall  one-cycle pulses, coincident with the first cycle of the new level
module debounce_channel
  import panel_input_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic IDLE            = 1'b0,
  parameter logic INVERT          = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int              CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;

  logic w_in;
  logic w_flip;

  assign w_in   = r_sync2 ^ INVERT;
  // The sample at this edge is the DEBOUNCE_CYCLES-th disagreeing one in a row.
  assign w_flip = (w_in != r_level) && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= IDLE;
      r_sync2 <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= w_flip & w_in;
      r_fall  <= w_flip & ~w_in;
      if ((w_in == r_level) || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_flip) begin
        r_level <= w_in;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/panel_input_conditioner.sv
// rtl/panel_input_conditioner.sv - front-panel key/switch conditioner with auto-repeat
// Purpose: debounces 4 active-low keys and 10 switches, produces press/release
//          pulses, key auto-repeat ticks and a switch-change pulse.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_keys            raw keys, 0 = pressed
//   i_switches        raw switches, 1 = up
//   o_key_level       debounced keys, 1 = pressed
//   o_key_press       one-cycle pulse on debounced press
//   o_key_release     one-cycle pulse on debounced release
//   o_key_repeat      one-cycle auto-repeat tick while held
//   o_switch_level    debounced switches
//   o_switch_change   one-cycle pulse when any debounced switch changes
module panel_input_conditioner
  import panel_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_KEYS-1:0]     i_keys,
  input  logic [NUM_SWITCHES-1:0] i_switches,
  output logic [NUM_KEYS-1:0]     o_key_level,
  output logic [NUM_KEYS-1:0]     o_key_press,
  output logic [NUM_KEYS-1:0]     o_key_release,
  output logic [NUM_KEYS-1:0]     o_key_repeat,
  output logic [NUM_SWITCHES-1:0] o_switch_level,
  output logic                    o_switch_change
);

  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW       = cnt_width(HOLD_MAX);

  logic [NUM_SWITCHES-1:0] w_sw_rise;
  logic [NUM_SWITCHES-1:0] w_sw_fall;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE            (KEY_IDLE),
      .INVERT          (1'b1)
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_raw   (i_keys[g]),
      .o_level (o_key_level[g]),
      .o_rise  (o_key_press[g]),
      .o_fall  (o_key_release[g])
    );
  end

  for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE            (SWITCH_IDLE),
      .INVERT          (1'b0)
    ) u_chan (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_raw   (i_switches[g]),
      .o_level (o_switch_level[g]),
      .o_rise  (w_sw_rise[g]),
      .o_fall  (w_sw_fall[g])
    );
  end

  assign o_switch_change = |(w_sw_rise | w_sw_fall);

  // Auto-repeat: the hold counter is zero throughout the press cycle because
  // the level was low just before it, so counting the press cycle as 1 puts
  // the first tick exactly HOLD_CYCLES after the press. After each tick the
  // counter restarts against REPEAT_CYCLES.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_rep
    logic [HW-1:0] r_hold;
    logic          r_repeating;
    logic          r_repeat;
    logic [HW:0]   w_next;
    logic [HW:0]   w_thr;
    logic          w_fire;

    assign w_next = {1'b0, r_hold} + 1'b1;
    assign w_thr  = r_repeating ? (HW+1)'(REPEAT_CYCLES) : (HW+1)'(HOLD_CYCLES);
    assign w_fire = o_key_level[g] && (w_next >= w_thr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_hold      <= '0;
        r_repeating <= 1'b0;
        r_repeat    <= 1'b0;
      end else if (!o_key_level[g]) begin
        r_hold      <= '0;
        r_repeating <= 1'b0;
        r_repeat    <= 1'b0;
      end else if (w_fire) begin
        r_hold      <= '0;
        r_repeating <= 1'b1;
        r_repeat    <= 1'b1;
      end else begin
        r_hold      <= w_next[HW-1:0];
        r_repeat    <= 1'b0;
      end
    end

    // A tick that lands on the release cycle is dropped.
    assign o_key_repeat[g] = r_repeat & ~o_key_release[g];
  end

endmodule
